sprite_move_scheduler: RTL and testbench
========================================

Name: sprite_move_scheduler

Overview:
Converts PS/2 arrow-key events into movement of the on-screen square and drives the square's top-left coordinate registers used by the pixel-select logic of the VGA controller.
- Key events come from the PS/2 domain. They are synchronised into iVGA_CLK, filtered to arrow codes and queued in a small FIFO.
- Queued moves are applied only at frame start, on the falling edge of VS. The coordinates therefore never change during active video, which eliminates tearing.
- Each move is clamped to the playfield bounds.

Parameters:
- STEP, 5: pixels moved per key event.
- X_INIT, 220: reset value of oX (row coordinate).
- Y_INIT, 300: reset value of oY (column coordinate).
- X_MAX, 427: largest legal oX.
- Y_MAX, 600: largest legal oY.
- DEPTH, 4: key FIFO depth; must be a power of 2, >= 2.
- MOVES_PER_FRAME, 1: maximum queued moves applied per frame.

Ports:
- iVGA_CLK, input, 1: pixel clock.
- iRST_n, input, 1: asynchronous active-low reset.
- ps2_out, input, 8: PS/2 scan code; stable while ps2_key_pressed is high.
- ps2_key_pressed, input, 1: asynchronous key strobe, active high.
- iVS, input, 1: vertical sync from the sync generator, active low.
- oX, output, 10: square row coordinate.
- oY, output, 10: square column coordinate.
- oBusy, output, 1: high while in the APPLY state.
- oDrop, output, 1: one-cycle pulse when an arrow event is discarded because the FIFO is full.
- oLevel, output, clog2(DEPTH)+1: current FIFO occupancy.

Behaviour:

Reset and constants
- Reset values: oX=X_INIT, oY=Y_INIT, oBusy=0, oDrop=0, oLevel=0. The FIFO is flushed and the FSM enters IDLE.
- Arrow codes: UP 8'h75, DOWN 8'h72, LEFT 8'h6b, RIGHT 8'h74.

Key capture
- ps2_key_pressed passes through a 2-flop synchroniser, then a rising-edge detector.
- On the detected edge cycle, ps2_out is sampled.
- If the sample is an arrow code, it is encoded to 2 bits (UP=0, DOWN=1, LEFT=2, RIGHT=3) and pushed. Non-arrow codes are ignored with no drop pulse.
- A held key produces exactly one event. Edge to push latency is 3 cycles from the asynchronous rise (2 synchroniser + 1 edge detect).

FIFO
- Circular buffer with pointers that wrap modulo DEPTH.
- Push when full: the entry is dropped, oDrop pulses for 1 cycle and the contents are unchanged.
- Push and pop in the same cycle are both performed and the level is unchanged. This holds when full: the pop frees a slot, the push is accepted and there is no drop.
- Pop when empty never occurs; the FSM guards it.

Frame detect
- iVS is registered. frame_start is asserted when the previous sample is 1 and the current sample is 0.

FSM
- IDLE:
  - On frame_start with level>0, go to APPLY with the per-frame counter cleared.
  - On frame_start with level==0, stay in IDLE.
- APPLY (oBusy=1):
  - Each cycle, pop the head entry and update the coordinate, registered, so it is visible the next cycle.
  - Increment the counter.
  - Go to IDLE when the counter reaches MOVES_PER_FRAME or the FIFO becomes empty after this pop.
- A frame_start that arrives while in APPLY is ignored. This cannot occur for sane parameters.

Arithmetic (all 10-bit unsigned, no wrap)
- UP: oX = (oX >= STEP) ? oX-STEP : 0.
- DOWN: oX = (oX+STEP <= X_MAX) ? oX+STEP : X_MAX. Compute in 11 bits.
- LEFT and RIGHT: the same rules on oY with Y_MAX.
- Coordinates update only in APPLY. They are constant from one APPLY exit to the next frame_start.

Reset mid-operation
- Asynchronous return to the reset values. Pending moves are lost.

Decomposition:
- Shared package vga_game_pkg holds:
  - the arrow scan-code localparams;
  - the 2-bit direction encoding;
  - the FSM state encoding (IDLE, APPLY);
  - the defaults for X_INIT, Y_INIT, X_MAX, Y_MAX and STEP, reused by the VGA controller's square-select logic.
- One natural sub-module, move_fifo: parameterised DEPTH × 2-bit synchronous FIFO with push, pop, full, empty and level. The synchroniser, edge detect, FSM and clamp arithmetic stay in the top module.

Test Plan:
1. Reset then run 2 frames with no keys -> oX=220, oY=300, oBusy never asserted, oLevel=0.
2. One UP press (8'h75) mid-frame -> oLevel=1 three cycles after the press; oX stays 220 until the next VS fall; oX=215 one cycle after APPLY; oBusy high for exactly 1 cycle.
3. Five RIGHT presses within one frame with DEPTH=4 -> fifth press pulses oDrop once; oLevel=4; oY steps 305, 310, 315, 320 over the next 4 frames, one step per frame.
4. oX=3, then UP -> oX=0. oX=425, then DOWN -> oX=427. oY=598, then RIGHT -> oY=600. oY=0, then LEFT -> oY=0.
5. Non-arrow code 8'h1C pressed, and one key held for 1000 cycles -> no push from 8'h1C and no oDrop; the held key yields exactly 1 push.
6. Push coinciding with APPLY pop while full (MOVES_PER_FRAME=1, level=4) -> no oDrop; level stays 4. Then assert iRST_n low mid-APPLY -> oX=220, oY=300, oLevel=0, oBusy=0 immediately.

Source files
------------

// File: rtl/vga_game_pkg.sv
// Shared VGA game definitions: arrow scan codes, move encoding, FSM states and
// square placement defaults used by the scheduler and the square-select logic.
package vga_game_pkg;

  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6b;
  localparam logic [7:0] KEY_RIGHT = 8'h74;

  localparam int unsigned COORD_W    = 10;
  localparam int unsigned DEF_STEP   = 5;
  localparam int unsigned DEF_X_INIT = 220;
  localparam int unsigned DEF_Y_INIT = 300;
  localparam int unsigned DEF_X_MAX  = 427;
  localparam int unsigned DEF_Y_MAX  = 600;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  function automatic logic is_arrow(input logic [7:0] code);
    return code inside {KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT};
  endfunction

  function automatic dir_e encode_dir(input logic [7:0] code);
    case (code)
      KEY_DOWN:  return DIR_DOWN;
      KEY_LEFT:  return DIR_LEFT;
      KEY_RIGHT: return DIR_RIGHT;
      default:   return DIR_UP;
    endcase
  endfunction

  // Saturating step towards zero.
  function automatic logic [COORD_W-1:0] clamp_dec(input logic [COORD_W-1:0] v,
                                                    input logic [COORD_W-1:0] step);
    return (v >= step) ? v - step : '0;
  endfunction

  // Step towards max with an extra carry bit so the sum cannot wrap.
  function automatic logic [COORD_W-1:0] clamp_inc(input logic [COORD_W-1:0] v,
                                                    input logic [COORD_W-1:0] step,
                                                    input logic [COORD_W-1:0] max);
    logic [COORD_W:0] sum;
    sum = {1'b0, v} + {1'b0, step};
    return (sum <= {1'b0, max}) ? sum[COORD_W-1:0] : max;
  endfunction

endpackage

// File: rtl/move_fifo.sv
// Small circular FIFO of queued moves; push while full is dropped unless a
// pop in the same cycle frees a slot.
module move_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic             iVGA_CLK,
  input  logic             iRST_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_c,
  output logic             empty_c,
  output logic [LW-1:0]    level,
  output logic             drop_c
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (level == LW'(DEPTH));
  assign empty_c = (level == '0);
  assign do_pop  = pop && !empty_c;
  assign do_push = push && (!full_c || do_pop);
  assign drop_c  = push && full_c && !do_pop;
  assign rdata_c = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sprite_move_scheduler.sv
// Turns PS/2 arrow-key events into square moves, applied only at frame start
// and clamped to the playfield.
module sprite_move_scheduler
  import vga_game_pkg::*;
#(
  parameter  int unsigned STEP            = DEF_STEP,
  parameter  int unsigned X_INIT          = DEF_X_INIT,
  parameter  int unsigned Y_INIT          = DEF_Y_INIT,
  parameter  int unsigned X_MAX           = DEF_X_MAX,
  parameter  int unsigned Y_MAX           = DEF_Y_MAX,
  parameter  int unsigned DEPTH           = 4,
  parameter  int unsigned MOVES_PER_FRAME = 1,
  localparam int unsigned LW              = $clog2(DEPTH) + 1
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_n,
  input  logic [7:0]         ps2_out,
  input  logic               ps2_key_pressed,
  input  logic               iVS,
  output logic [COORD_W-1:0] oX,
  output logic [COORD_W-1:0] oY,
  output logic               oBusy,
  output logic               oDrop,
  output logic [LW-1:0]      oLevel
);

  localparam int unsigned CNT_W = $clog2(MOVES_PER_FRAME + 1);

  logic             key_s1, key_s2, key_s3;
  logic             vs_d1, vs_d2;
  logic             key_push;
  logic             frame_start;
  logic             fifo_pop;
  logic [1:0]       head_dir;
  logic             fifo_full_c, fifo_empty_c, fifo_drop_c;
  state_e           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  coord_t           pos, pos_next;

  function automatic coord_t apply_move(input coord_t p, input dir_e d);
    coord_t r;
    r = p;
    case (d)
      DIR_UP:    r.x = clamp_dec(p.x, COORD_W'(STEP));
      DIR_DOWN:  r.x = clamp_inc(p.x, COORD_W'(STEP), COORD_W'(X_MAX));
      DIR_LEFT:  r.y = clamp_dec(p.y, COORD_W'(STEP));
      DIR_RIGHT: r.y = clamp_inc(p.y, COORD_W'(STEP), COORD_W'(Y_MAX));
    endcase
    return r;
  endfunction

  // Key strobe synchroniser with edge history; VS history resets high so
  // leaving reset never looks like a frame start.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      key_s1 <= 1'b0;
      key_s2 <= 1'b0;
      key_s3 <= 1'b0;
      vs_d1  <= 1'b1;
      vs_d2  <= 1'b1;
    end else begin
      key_s1 <= ps2_key_pressed;
      key_s2 <= key_s1;
      key_s3 <= key_s2;
      vs_d1  <= iVS;
      vs_d2  <= vs_d1;
    end
  end

  assign key_push    = key_s2 && !key_s3 && is_arrow(ps2_out);
  assign frame_start = vs_d2 && !vs_d1;

  move_fifo #(.DEPTH(DEPTH), .WIDTH(2)) u_fifo (
    .iVGA_CLK (iVGA_CLK),
    .iRST_n   (iRST_n),
    .push     (key_push),
    .wdata    (2'(encode_dir(ps2_out))),
    .pop      (fifo_pop),
    .rdata_c  (head_dir),
    .full_c   (fifo_full_c),
    .empty_c  (fifo_empty_c),
    .level    (oLevel),
    .drop_c   (fifo_drop_c)
  );

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      pos   <= '{x: COORD_W'(X_INIT), y: COORD_W'(Y_INIT)};
      oDrop <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      pos   <= pos_next;
      oDrop <= fifo_drop_c;
    end
  end

  // Next state: one pop and coordinate update per APPLY cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pos_next   = pos;
    fifo_pop   = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_next = '0;
        if (frame_start && !fifo_empty_c) state_next = ST_APPLY;
      end
      ST_APPLY: begin
        fifo_pop = 1'b1;
        cnt_next = cnt + CNT_W'(1);
        pos_next = apply_move(pos, dir_e'(head_dir));
        if (cnt_next == CNT_W'(MOVES_PER_FRAME) ||
            (oLevel == LW'(1) && !key_push))
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign oX    = pos.x;
  assign oY    = pos.y;
  assign oBusy = (state == ST_APPLY);

endmodule

// File: tb/tb_sprite_move_scheduler.sv
// Bench for sprite_move_scheduler: expected coordinates are queued per key
// press and checked by a monitor whenever an APPLY cycle completes.
module tb_sprite_move_scheduler;
  import vga_game_pkg::*;

  logic       iVGA_CLK = 1'b0;
  logic       iRST_n;
  logic [7:0] ps2_out;
  logic       ps2_key_pressed;
  logic       iVS;
  logic [9:0] oX, oY;
  logic       oBusy, oDrop;
  logic [2:0] oLevel;

  always #5 iVGA_CLK = ~iVGA_CLK;

  sprite_move_scheduler dut (
    .iVGA_CLK        (iVGA_CLK),
    .iRST_n          (iRST_n),
    .ps2_out         (ps2_out),
    .ps2_key_pressed (ps2_key_pressed),
    .iVS             (iVS),
    .oX              (oX),
    .oY              (oY),
    .oBusy           (oBusy),
    .oDrop           (oDrop),
    .oLevel          (oLevel)
  );

  typedef struct {
    int x;
    int y;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors    = 0;
  int   miscompares = 0;
  int   mx = 220, my = 300, exp_level = 0, exp_drops = 0;
  int   drop_seen = 0, busy_seen = 0;
  logic busy_d = 1'b0;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: the cycle after oBusy the new coordinate must be visible.
  always @(negedge iVGA_CLK) begin
    if (oDrop) drop_seen++;
    if (oBusy) busy_seen++;
    if (busy_d && iRST_n) begin
      check("busy_len", int'(oBusy), 0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL move_unexpected: got x=%0d y=%0d, expected no move", oX, oY);
      end else begin
        mon_e = exp_q.pop_front();
        check("move_x", int'(oX), mon_e.x);
        check("move_y", int'(oY), mon_e.y);
      end
    end
    busy_d = oBusy && iRST_n;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge iVGA_CLK);
    #1;
  endtask

  task automatic model_move(input logic [7:0] code);
    case (code)
      KEY_UP:    mx = (mx >= 5) ? mx - 5 : 0;
      KEY_DOWN:  mx = (mx + 5 <= 427) ? mx + 5 : 427;
      KEY_LEFT:  my = (my >= 5) ? my - 5 : 0;
      KEY_RIGHT: my = (my + 5 <= 600) ? my + 5 : 600;
      default: ;
    endcase
  endtask

  task automatic press(input logic [7:0] code, input int hold);
    ps2_out = code;
    ps2_key_pressed = 1'b1;
    tick(hold);
    ps2_key_pressed = 1'b0;
    tick(3);
  endtask

  task automatic arrow(input logic [7:0] code, input int hold);
    if (exp_level == 4) exp_drops++;
    else begin
      exp_level++;
      model_move(code);
      exp_q.push_back('{mx, my});
    end
    press(code, hold);
  endtask

  task automatic frame();
    iVS = 1'b0;
    tick(4);
    iVS = 1'b1;
    tick(4);
    if (exp_level > 0) exp_level--;
  endtask

  task automatic move(input logic [7:0] code);
    arrow(code, 2);
    frame();
  endtask

  int b0, d0;

  initial begin
    iRST_n = 1'b0; iVS = 1'b1; ps2_key_pressed = 1'b0; ps2_out = 8'h00;
    tick(3);
    check("rst_x", int'(oX), 220);
    check("rst_y", int'(oY), 300);
    check("rst_busy", int'(oBusy), 0);
    check("rst_drop", int'(oDrop), 0);
    check("rst_level", int'(oLevel), 0);
    iRST_n = 1'b1;
    tick(2);

    // Idle frames
    frame(); frame();
    check("idle_x", int'(oX), 220);
    check("idle_y", int'(oY), 300);
    check("idle_level", int'(oLevel), 0);
    check("idle_busy_cycles", busy_seen, 0);

    // Single UP press, latency and deferred application
    ps2_out = KEY_UP; ps2_key_pressed = 1'b1;
    exp_level = 1; mx = 215; exp_q.push_back('{215, 300});
    tick(2);
    check("lat_level_2cyc", int'(oLevel), 0);
    tick(1);
    check("lat_level_3cyc", int'(oLevel), 1);
    ps2_key_pressed = 1'b0;
    tick(8);
    check("x_hold_before_vs", int'(oX), 220);
    b0 = busy_seen;
    frame();
    check("up_x", int'(oX), 215);
    check("up_busy_cycles", busy_seen - b0, 1);
    check("up_level", int'(oLevel), 0);

    // Overflow: fifth press dropped, then one move per frame
    d0 = drop_seen;
    repeat (5) arrow(KEY_RIGHT, 2);
    check("ovf_drops", drop_seen - d0, 1);
    check("ovf_level", int'(oLevel), 4);
    for (int i = 0; i < 4; i++) begin
      frame();
      check("ovf_y_step", int'(oY), 305 + 5 * i);
      check("ovf_level_drain", int'(oLevel), 3 - i);
    end

    // Non-arrow code and a long hold
    d0 = drop_seen;
    press(8'h1C, 3);
    check("nonarrow_level", int'(oLevel), 0);
    check("nonarrow_drop", drop_seen - d0, 0);
    arrow(KEY_LEFT, 1000);
    check("held_level", int'(oLevel), 1);
    frame();
    check("held_y", int'(oY), 315);

    // Playfield bounds
    while (mx > 0) move(KEY_UP);
    check("bound_x0", int'(oX), 0);
    move(KEY_UP);
    check("bound_up_clamp", int'(oX), 0);
    while (mx < 425) move(KEY_DOWN);
    check("bound_x425", int'(oX), 425);
    move(KEY_DOWN);
    check("bound_down_clamp", int'(oX), 427);
    move(KEY_DOWN);
    check("bound_down_hold", int'(oX), 427);
    while (my < 600) move(KEY_RIGHT);
    check("bound_y600", int'(oY), 600);
    move(KEY_RIGHT);
    check("bound_right_clamp", int'(oY), 600);
    while (my > 0) move(KEY_LEFT);
    check("bound_y0", int'(oY), 0);
    move(KEY_LEFT);
    check("bound_left_clamp", int'(oY), 0);
    check("all_moves_applied", exp_q.size(), 0);

    // Push coinciding with the APPLY pop while full
    repeat (4) arrow(KEY_RIGHT, 2);
    check("full_level", int'(oLevel), 4);
    d0 = drop_seen;
    model_move(KEY_RIGHT);
    exp_q.push_back('{mx, my});
    iVS = 1'b0; ps2_out = KEY_RIGHT; ps2_key_pressed = 1'b1;
    tick(3);
    check("pushpop_level", int'(oLevel), 4);
    ps2_key_pressed = 1'b0;
    tick(1);
    iVS = 1'b1;
    tick(4);
    check("pushpop_drop", drop_seen - d0, 0);
    check("pushpop_level_after", int'(oLevel), 4);
    check("pushpop_y", int'(oY), 5);

    // Reset in the middle of APPLY
    iVS = 1'b0;
    tick(2);
    check("apply_busy", int'(oBusy), 1);
    iRST_n = 1'b0;
    #1;
    check("midrst_x", int'(oX), 220);
    check("midrst_y", int'(oY), 300);
    check("midrst_level", int'(oLevel), 0);
    check("midrst_busy", int'(oBusy), 0);
    check("midrst_drop", int'(oDrop), 0);
    exp_q.delete();
    mx = 220; my = 300; exp_level = 0;
    tick(2);
    iVS = 1'b1;
    iRST_n = 1'b1;
    tick(3);
    b0 = busy_seen;
    frame();
    check("post_rst_busy", busy_seen - b0, 0);
    check("post_rst_x", int'(oX), 220);
    check("post_rst_y", int'(oY), 300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
